cdb_arbiter: RTL and testbench

Parametrised common-data-bus arbiter for the Tomasulo core. Collects ready-to-send requests from `N_UNITS` execution units (adders, multipliers, load units, …) and grants the bus to one unit per cycle using round-robin priority. The winning unit's result and reservation-station source tag are broadcast, registered, to the register file and to all reservation stations. It generalises the single-adder `rts`/`xmit` handshake to N units and adds a hold input.

---
 rtl/tomasulo_pkg.sv | 16 +
 rtl/cdb_arbiter_rr_picker.sv | 40 ++++
 rtl/cdb_arbiter.sv | 87 ++++++++
 tb/tb_cdb_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo core.
//   DEFAULT_DATA_W / DEFAULT_TAG_W : default result and tag widths
//   NO_SOURCE                      : all-zero tag, "no reservation station"
//   idx_w(n)                       : width of an index into n units (min 1)
package tomasulo_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_TAG_W  = 6;

  localparam logic [DEFAULT_TAG_W-1:0] NO_SOURCE = '0;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   elig  : request vector of candidates
//   ptr   : highest-priority position this cycle (0..N-1)
//   found : at least one candidate is eligible
//   grant : one-hot winner
//   idx   : binary index of the winner
// Search order is ptr, ptr+1, ... wrapping modulo N; the first hit wins.
module rr_picker
  import tomasulo_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int off = 0; off < N; off++) begin
      int j;
      // ptr is always < N, so one conditional subtract implements the wrap.
      j = int'(ptr) + off;
      if (j >= N) j = j - N;
      if (!found && elig[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants the CDB to one of N_UNITS execution units
// per cycle in round-robin order and broadcasts the winner's result and tag.
//   clock, reset_n : clock and asynchronous active-low reset
//   rts            : per-unit ready-to-send
//   unit_data      : unit i result in [i*DATA_W +: DATA_W]
//   unit_source    : unit i tag in [i*TAG_W +: TAG_W]
//   cdb_hold       : suppress any grant this edge (pointer frozen)
//   xmit           : one-cycle grant pulse, one-hot
//   CDB_data       : broadcast result (holds last value when idle)
//   CDB_source     : broadcast tag (NO_SOURCE when idle)
//   CDB_write      : broadcast valid, coincident with xmit
// All outputs are registered.
module cdb_arbiter
  import tomasulo_pkg::*;
#(
  parameter int N_UNITS = 2,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int TAG_W   = DEFAULT_TAG_W
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [N_UNITS-1:0]         rts,
  input  logic [N_UNITS*DATA_W-1:0]  unit_data,
  input  logic [N_UNITS*TAG_W-1:0]   unit_source,
  input  logic                       cdb_hold,
  output logic [N_UNITS-1:0]         xmit,
  output logic [DATA_W-1:0]          CDB_data,
  output logic [TAG_W-1:0]           CDB_source,
  output logic                       CDB_write
);

  localparam int IW = idx_w(N_UNITS);

  logic [IW-1:0]      ptr;
  logic [N_UNITS-1:0] elig;
  logic               found;
  logic [N_UNITS-1:0] grant;
  logic [IW-1:0]      win_idx;
  logic [DATA_W-1:0]  sel_data;
  logic [TAG_W-1:0]   sel_src;

  // A unit granted last cycle still shows its stale rts this edge; mask it.
  assign elig = rts & ~xmit;

  rr_picker #(.N(N_UNITS), .IW(IW)) u_picker (
    .elig  (elig),
    .ptr   (ptr),
    .found (found),
    .grant (grant),
    .idx   (win_idx)
  );

  // AND-OR mux driven by the one-hot grant.
  always_comb begin
    sel_data = '0;
    sel_src  = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      sel_data = sel_data | (unit_data[i*DATA_W +: DATA_W] & {DATA_W{grant[i]}});
      sel_src  = sel_src  | (unit_source[i*TAG_W +: TAG_W] & {TAG_W{grant[i]}});
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr        <= '0;
      xmit       <= '0;
      CDB_write  <= 1'b0;
      CDB_data   <= '0;
      CDB_source <= '0;
    end else if (found && !cdb_hold) begin
      xmit       <= grant;
      CDB_write  <= 1'b1;
      CDB_data   <= sel_data;
      CDB_source <= sel_src;
      ptr        <= (win_idx == IW'(N_UNITS - 1)) ? '0 : win_idx + IW'(1);
    end else begin
      // Idle: drop the tag so tag-matching consumers ignore the bus;
      // CDB_data keeps its last value.
      xmit       <= '0;
      CDB_write  <= 1'b0;
      CDB_source <= TAG_W'(NO_SOURCE);
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: a table-driven N_UNITS=3 sequence
// (contention, hold, wrap, masking) plus hand-written sequences for the
// N_UNITS=2 single-request and asynchronous-reset cases and N_UNITS=1.
module tb_cdb_arbiter;

  logic clock;
  logic reset_n;

  int checks = 0;
  int errors = 0;

  // N_UNITS = 3 instance
  logic [2:0]  rts3;
  logic [95:0] data3;
  logic [17:0] src3;
  logic        hold3;
  logic [2:0]  xmit3;
  logic [31:0] cdata3;
  logic [5:0]  csrc3;
  logic        cwr3;

  // N_UNITS = 2 instance
  logic [1:0]  rts2;
  logic [63:0] data2;
  logic [11:0] src2;
  logic        hold2;
  logic [1:0]  xmit2;
  logic [31:0] cdata2;
  logic [5:0]  csrc2;
  logic        cwr2;

  // N_UNITS = 1 instance
  logic        rts1;
  logic [31:0] data1;
  logic [5:0]  src1;
  logic        hold1;
  logic        xmit1;
  logic [31:0] cdata1;
  logic [5:0]  csrc1;
  logic        cwr1;

  cdb_arbiter #(.N_UNITS(3), .DATA_W(32), .TAG_W(6)) u3 (
    .clock(clock), .reset_n(reset_n), .rts(rts3), .unit_data(data3),
    .unit_source(src3), .cdb_hold(hold3), .xmit(xmit3), .CDB_data(cdata3),
    .CDB_source(csrc3), .CDB_write(cwr3)
  );

  cdb_arbiter #(.N_UNITS(2), .DATA_W(32), .TAG_W(6)) u2 (
    .clock(clock), .reset_n(reset_n), .rts(rts2), .unit_data(data2),
    .unit_source(src2), .cdb_hold(hold2), .xmit(xmit2), .CDB_data(cdata2),
    .CDB_source(csrc2), .CDB_write(cwr2)
  );

  cdb_arbiter #(.N_UNITS(1), .DATA_W(32), .TAG_W(6)) u1 (
    .clock(clock), .reset_n(reset_n), .rts(rts1), .unit_data(data1),
    .unit_source(src1), .cdb_hold(hold1), .xmit(xmit1), .CDB_data(cdata1),
    .CDB_source(csrc1), .CDB_write(cwr1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] rts;
    logic       hold;
    logic [2:0] exp_xmit;
    logic       exp_write;
    logic [5:0] exp_src;
  } vec_t;

  vec_t vec[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] exp_data3;

  initial begin
    // Table for N_UNITS=3; unit k has data 0x100+k and tag one-hot(k).
    // ptr starts at 0 after reset.
    vec[0]  = '{3'b111, 1'b0, 3'b001, 1'b1, 6'b000001}; // contention 0
    vec[1]  = '{3'b111, 1'b0, 3'b010, 1'b1, 6'b000010}; // 1
    vec[2]  = '{3'b111, 1'b0, 3'b100, 1'b1, 6'b000100}; // 2
    vec[3]  = '{3'b111, 1'b0, 3'b001, 1'b1, 6'b000001}; // 0 again
    vec[4]  = '{3'b111, 1'b0, 3'b010, 1'b1, 6'b000010};
    vec[5]  = '{3'b111, 1'b0, 3'b100, 1'b1, 6'b000100}; // ptr -> 0
    vec[6]  = '{3'b010, 1'b1, 3'b000, 1'b0, 6'b000000}; // hold x3
    vec[7]  = '{3'b010, 1'b1, 3'b000, 1'b0, 6'b000000};
    vec[8]  = '{3'b010, 1'b1, 3'b000, 1'b0, 6'b000000};
    vec[9]  = '{3'b010, 1'b0, 3'b010, 1'b1, 6'b000010}; // release, ptr -> 2
    vec[10] = '{3'b000, 1'b0, 3'b000, 1'b0, 6'b000000}; // idle
    vec[11] = '{3'b011, 1'b0, 3'b001, 1'b1, 6'b000001}; // ptr 2 wraps to 0
    vec[12] = '{3'b010, 1'b0, 3'b010, 1'b1, 6'b000010}; // ptr -> 2
    vec[13] = '{3'b100, 1'b0, 3'b100, 1'b1, 6'b000100}; // grant 2, ptr -> 0
    vec[14] = '{3'b011, 1'b0, 3'b001, 1'b1, 6'b000001}; // unit 0 wins
    vec[15] = '{3'b011, 1'b0, 3'b010, 1'b1, 6'b000010}; // stale rts[0] masked
    vec[16] = '{3'b000, 1'b0, 3'b000, 1'b0, 6'b000000};

    reset_n = 1'b1;
    rts3 = '0; hold3 = 1'b0;
    data3 = {32'h0000_0102, 32'h0000_0101, 32'h0000_0100};
    src3  = {6'b000100, 6'b000010, 6'b000001};
    rts2 = '0; hold2 = 1'b0; data2 = '0; src2 = '0;
    rts1 = 1'b0; hold1 = 1'b0; data1 = 32'h0000_0055; src1 = 6'b001000;

    #1 reset_n = 1'b0;
    #2;
    check("reset xmit3", 64'(xmit3), 64'd0);
    check("reset cwr3", 64'(cwr3), 64'd0);
    check("reset csrc3", 64'(csrc3), 64'd0);
    check("reset cdata3", 64'(cdata3), 64'd0);
    check("reset xmit2", 64'(xmit2), 64'd0);
    check("reset xmit1", 64'(xmit1), 64'd0);
    tick();
    tick();
    reset_n = 1'b1;

    // ---- Table-driven N_UNITS=3 sequence ----
    exp_data3 = 32'h0;
    for (int i = 0; i < 17; i++) begin
      rts3  = vec[i].rts;
      hold3 = vec[i].hold;
      tick();
      if (vec[i].exp_write) begin
        for (int k = 0; k < 3; k++)
          if (vec[i].exp_xmit[k]) exp_data3 = 32'h100 + 32'(k);
      end
      check($sformatf("vec%0d xmit", i), 64'(xmit3), 64'(vec[i].exp_xmit));
      check($sformatf("vec%0d write", i), 64'(cwr3), 64'(vec[i].exp_write));
      check($sformatf("vec%0d source", i), 64'(csrc3), 64'(vec[i].exp_src));
      check($sformatf("vec%0d data", i), 64'(cdata3), 64'(exp_data3));
    end

    // ---- N_UNITS=2: lone request from unit 1 ----
    rts2  = 2'b10;
    data2 = {32'h0000_00A5, 32'h0000_0011};
    src2  = {6'b000100, 6'b000001};
    tick();
    check("single xmit", 64'(xmit2), 64'h2);
    check("single write", 64'(cwr2), 64'h1);
    check("single data", 64'(cdata2), 64'hA5);
    check("single source", 64'(csrc2), 64'h04);
    tick(); // stale rts still high: must be masked
    check("masked xmit", 64'(xmit2), 64'h0);
    check("masked write", 64'(cwr2), 64'h0);
    check("masked source", 64'(csrc2), 64'h0);
    check("masked data hold", 64'(cdata2), 64'hA5);

    // ---- N_UNITS=2: reset mid-grant ----
    rts2 = 2'b00;
    tick();
    rts2 = 2'b11;
    tick(); // ptr was 0 -> unit 0 granted, ptr -> 1
    check("pre-reset xmit", 64'(xmit2), 64'h1);
    reset_n = 1'b0;
    #1;
    check("async reset xmit", 64'(xmit2), 64'h0);
    check("async reset write", 64'(cwr2), 64'h0);
    check("async reset data", 64'(cdata2), 64'h0);
    check("async reset source", 64'(csrc2), 64'h0);
    tick();
    check("reset held xmit", 64'(xmit2), 64'h0);
    reset_n = 1'b1;
    tick(); // ptr back to 0 -> unit 0 first
    check("post-reset xmit", 64'(xmit2), 64'h1);
    check("post-reset data", 64'(cdata2), 64'h11);
    check("post-reset source", 64'(csrc2), 64'h01);
    tick();
    check("post-reset next xmit", 64'(xmit2), 64'h2);
    rts2 = 2'b00;

    // ---- N_UNITS=1: continuous request granted every other cycle ----
    rts1 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("legacy%0d xmit", c), 64'(xmit1), (c % 2 == 0) ? 64'h1 : 64'h0);
      check($sformatf("legacy%0d write", c), 64'(cwr1), (c % 2 == 0) ? 64'h1 : 64'h0);
    end
    check("legacy data", 64'(cdata1), 64'h55);
    rts1 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
